// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : Byte-addressed big-endian data memory for the MIPS MEM stage.
//               Valid/ready request and pulsed response, with configurable
//               read latency. Define DMEM_ALIGN_CHECK_EN to reject misaligned
//               half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int                 c_IDX_W     = $clog2(DEPTH_BYTES);
    localparam int                 c_CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [ADDR_W:0]    c_DEPTH     = (ADDR_W + 1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam state_t c_ACCEPT_STATE = (LATENCY > 1) ? S_WAIT : S_RESP;

    logic [7:0]         r_mem [0:DEPTH_BYTES-1];
    state_t             r_state;
    state_t             w_nextState;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [31:0]        r_pendData;
    logic               r_pendErr;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_accept;
    logic [1:0]         w_nbm1;
    logic [ADDR_W:0]    w_endAddr;
    logic               w_alignErr;
    logic               w_err;
    logic [c_IDX_W-1:0] w_base;
    logic [c_IDX_W-1:0] w_idx [0:3];
    logic [3:0][7:0]    w_rdByte;
    logic [3:0][7:0]    w_wrByte;
    logic [3:0]         w_wrEn;
    logic [31:0]        w_loadData;

    assign req_ready  = (r_state == S_IDLE) || (r_state == S_RESP);
    // Requests presented while reset is asserted must not touch the array.
    assign w_accept   = req_valid & req_ready & rst_n;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err & (r_state == S_RESP);

    always_comb begin
        w_nbm1 = 2'd0;
        case (req_size)
            2'b01:   w_nbm1 = 2'd1;
            2'b10:   w_nbm1 = 2'd3;
            default: w_nbm1 = 2'd0;
        endcase
    end

    // One extra bit keeps the end address from wrapping past the top of ADDR_W.
    assign w_endAddr = {1'b0, req_addr} + {{(ADDR_W - 1){1'b0}}, w_nbm1};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_alignErr = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_alignErr = 1'b0;
`endif

    assign w_err  = (req_size == 2'b11) || (w_endAddr >= c_DEPTH) || w_alignErr;
    assign w_base = req_addr[c_IDX_W-1:0];

    // Lane 0 is the byte at the request address, i.e. the most significant one.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_idx[gi]    = w_base + c_IDX_W'(gi);
        assign w_rdByte[gi] = r_mem[w_idx[gi]];
    end

    always_comb begin
        w_wrByte = '0;
        w_wrEn   = 4'b0000;
        case (req_size)
            2'b00: begin
                w_wrByte[0] = req_wdata[7:0];
                w_wrEn      = 4'b0001;
            end
            2'b01: begin
                w_wrByte[0] = req_wdata[15:8];
                w_wrByte[1] = req_wdata[7:0];
                w_wrEn      = 4'b0011;
            end
            2'b10: begin
                w_wrByte[0] = req_wdata[31:24];
                w_wrByte[1] = req_wdata[23:16];
                w_wrByte[2] = req_wdata[15:8];
                w_wrByte[3] = req_wdata[7:0];
                w_wrEn      = 4'b1111;
            end
            default: begin
                w_wrByte = '0;
                w_wrEn   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        w_loadData = 32'h0;
        if (!req_we && !w_err) begin
            case (req_size)
                2'b00:   w_loadData = {{24{w_rdByte[0][7] & ~req_unsigned}}, w_rdByte[0]};
                2'b01:   w_loadData = {{16{w_rdByte[0][7] & ~req_unsigned}},
                                       w_rdByte[0], w_rdByte[1]};
                2'b10:   w_loadData = {w_rdByte[0], w_rdByte[1], w_rdByte[2], w_rdByte[3]};
                default: w_loadData = 32'h0;
            endcase
        end
    end

    // Storage is deliberately not reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wrEn[i]) begin
                    r_mem[w_idx[i]] <= w_wrByte[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_RESP: w_nextState = w_accept ? c_ACCEPT_STATE : S_IDLE;
            S_WAIT:         w_nextState = (r_waitCnt == c_WAIT_LAST) ? S_RESP : S_WAIT;
            default:        w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt  <= '0;
            r_pendData <= 32'h0;
            r_pendErr  <= 1'b0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_waitCnt  <= '0;
                r_pendData <= w_loadData;
                r_pendErr  <= w_err;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt + c_CNT_W'(1);
            end
            // Entering RESP from WAIT uses the held result, otherwise the live one.
            if (w_nextState == S_RESP) begin
                r_rdata <= (r_state == S_WAIT) ? r_pendData : w_loadData;
                r_err   <= (r_state == S_WAIT) ? r_pendErr  : w_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Self-checking bench for data_memory_ctrl (LATENCY=1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqValid3 = 1'b0;
    logic        reqWe = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqAddr = 32'h0;
    logic [31:0] reqWdata = 32'h0;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        ready3, valid3, err3;
    logic [31:0] rdata3;

    int          nTests = 0;
    int          nFail = 0;
    int          respCount = 0;
    int          resp3Count = 0;
    logic [32:0] expQ [$];
    logic [32:0] expHead;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_BYTES(512), .ADDR_W(32), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid), .req_ready(req_ready), .req_we(reqWe),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    data_memory_ctrl #(.DEPTH_BYTES(512), .ADDR_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid3), .req_ready(ready3), .req_we(reqWe),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata), .resp_valid(valid3), .resp_rdata(rdata3),
        .resp_err(err3)
    );

    // Scoreboard: every response of the LATENCY=1 instance is popped and compared.
    always @(negedge clk) begin
        nTests++;
        if (resp_valid) begin
            respCount++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("FAIL unexpected_resp: got err=%b rdata=%h, required no response",
                         resp_err, resp_rdata);
            end else begin
                expHead = expQ.pop_front();
                if ({resp_err, resp_rdata} !== expHead)
                    begin
                        nFail++;
                        $display("FAIL resp #%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                                 respCount, resp_err, resp_rdata, expHead[32], expHead[31:0]);
                    end
            end
        end else if (resp_err !== 1'b0) begin
            nFail++;
            $display("FAIL err_unqualified: got resp_err=%b, required 0", resp_err);
        end
        if (valid3) resp3Count++;
    end

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic expErr, input logic [31:0] expData);
        reqValid    = 1'b1;
        reqWe       = we;
        reqSize     = sz;
        reqUnsigned = uns;
        reqAddr     = a;
        reqWdata    = wd;
        expQ.push_back({expErr, expData});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        reqValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        reqValid = 1'b1;
        reqAddr  = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nTests++;
            if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'h0) begin
                nFail++;
                $display("FAIL reset_during: got ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00000000",
                         req_ready, resp_valid, resp_err, resp_rdata);
            end
        end
        reqValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        nTests++;
        if ({req_ready, resp_valid, resp_err, ready3} !== 4'b1001 || resp_rdata !== 32'h0) begin
            nFail++;
            $display("FAIL reset_after: got ready=%b valid=%b err=%b ready3=%b rdata=%h, required 1 0 0 1 00000000",
                     req_ready, resp_valid, resp_err, ready3, resp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int base;
        base = respCount;
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);
        @(negedge clk); #1;
        nTests++;
        if (respCount !== base + 1 || req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL b2b_1: got responses=%0d ready=%b, required %0d 1", respCount - base, req_ready, 1);
        end
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11223344);
        @(negedge clk); #1;
        nTests++;
        if (respCount !== base + 2 || req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL b2b_2: got responses=%0d ready=%b, required %0d 1", respCount - base, req_ready, 2);
        end
        send(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00000033);
        @(negedge clk); #1;
        nTests++;
        if (respCount !== base + 3) begin
            nFail++;
            $display("FAIL b2b_3: got responses=%0d, required %0d", respCount - base, 3);
        end
        send(1'b1, 2'b01, 1'b0, 32'h14, 32'h1234BEEF, 1'b0, 32'h0);
        send(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b0, 32'h0000BEEF);
        send(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0, 32'hFFFFFFEF);
        idle(3);
    endtask

    task automatic test_sign_ext();
        send(1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, 1'b0, 32'h0);
        send(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF01, 1'b0, 32'h0);
        send(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFFFF80);
        send(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00000080);
        send(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF8001);
        send(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00008001);
        send(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'h00000001);
        send(1'b1, 2'b10, 1'b0, 32'h24, 32'h80000001, 1'b0, 32'h0);
        send(1'b0, 2'b10, 1'b1, 32'h24, 32'h0, 1'b0, 32'h80000001);
        idle(3);
    endtask

    task automatic test_errors();
        send(1'b1, 2'b10, 1'b0, 32'h0,        32'h01020304, 1'b0, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h1FC,      32'hCAFEF00D, 1'b0, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h1FE,      32'h0,        1'b1, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h200,      32'hDEADBEEF, 1'b1, 32'h0);
        send(1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0);
        send(1'b1, 2'b11, 1'b0, 32'h4,        32'hFFFFFFFF, 1'b1, 32'h0);
        send(1'b0, 2'b01, 1'b0, 32'h1FF,      32'h0,        1'b1, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h55555555, 1'b1, 32'h0);
        send(1'b0, 2'b00, 1'b0, 32'h1FF,      32'h0,        1'b0, 32'h0000000D);
        send(1'b0, 2'b10, 1'b0, 32'h1FC,      32'h0,        1'b0, 32'hCAFEF00D);
        send(1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0, 32'h01020304);
        idle(3);
    endtask

    task automatic test_unaligned();
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, 1'b0, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h14, 32'h05060708, 1'b0, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        send(1'b1, 2'b10, 1'b0, 32'h11, 32'hAABBCCDD, 1'b1, 32'h0);
        send(1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h01020304);
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        1'b0, 32'h05060708);
`else
        send(1'b1, 2'b10, 1'b0, 32'h11, 32'hAABBCCDD, 1'b0, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        1'b0, 32'hAABBCCDD);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h01AABBCC);
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        1'b0, 32'hDD060708);
        send(1'b0, 2'b01, 1'b1, 32'h13, 32'h0,        1'b0, 32'h0000CCDD);
`endif
        idle(3);
    endtask

    task automatic test_latency_reset();
        int n;
        int base;
        reqValid = 1'b0;
        // Store a known word into the LATENCY=3 instance and time its response.
        reqValid3 = 1'b1; reqWe = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h40; reqWdata = 32'h5A5AA5A5;
        @(posedge clk); #1;
        reqValid3 = 1'b0;
        @(negedge clk);
        nTests++;
        if (ready3 !== 1'b0) begin
            nFail++;
            $display("FAIL lat3_wait_ready: got ready=%b, required 0", ready3);
        end
        n = 1;
        while (!valid3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        nTests++;
        if (n !== 3 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
            nFail++;
            $display("FAIL lat3_store: got latency=%0d err=%b rdata=%h, required 3 0 00000000", n, err3, rdata3);
        end
        @(posedge clk); #1;
        // Load, then reset one cycle after accept: the response must be dropped.
        reqValid3 = 1'b1; reqWe = 1'b0;
        @(posedge clk); #1;
        reqValid3 = 1'b0;
        base = resp3Count;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        nTests++;
        if (resp3Count !== base || ready3 !== 1'b1 || rdata3 !== 32'h0) begin
            nFail++;
            $display("FAIL lat3_reset_drop: got pulses=%0d ready=%b rdata=%h, required 0 1 00000000",
                     resp3Count - base, ready3, rdata3);
        end
        @(posedge clk); #1;
        reqValid3 = 1'b1;
        @(posedge clk); #1;
        reqValid3 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid3 && n < 10);
        nTests++;
        if (n !== 3 || err3 !== 1'b0 || rdata3 !== 32'h5A5AA5A5) begin
            nFail++;
            $display("FAIL lat3_load: got latency=%0d err=%b rdata=%h, required 3 0 5a5aa5a5", n, err3, rdata3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sign_ext();
        test_errors();
        test_unaligned();
        test_latency_reset();
        idle(2);
        nTests++;
        if (expQ.size() !== 0) begin
            nFail++;
            $display("FAIL missing_resp: got %0d outstanding, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
